// File: rtl/game_state_controller.sv
`default_nettype none
// ============================================================================
// Module      : game_state_controller
// Description : Top-level game sequencer. It selects the game screen (title,
//               playing, level clear, game won, game over) and tracks lives,
//               the current level and the post-hit invulnerability window.
//               It also issues a one-cycle levelRestart pulse for each new
//               level.
// Revision    : 1.0 - initial release
// ============================================================================
module game_state_controller #(
    parameter int LIVES               = 3,
    parameter int MAX_LEVEL           = 3,
    parameter int SCREEN_HOLD_FRAMES  = 120,
    parameter int HIT_COOLDOWN_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       startKey,
    input  logic       won,
    input  logic       playerHit,
    input  logic       aliensLanded,
    output logic       levelRestart,
    output logic       titleScreen,
    output logic       gameActive,
    output logic       levelClear,
    output logic       gameWon,
    output logic       gameOver,
    output logic [2:0] livesLeft,
    output logic [2:0] level,
    output logic       invulnerable
);

    localparam int c_COOL_W = $clog2(HIT_COOLDOWN_FRAMES + 1);
    localparam int c_HOLD_W = $clog2(SCREEN_HOLD_FRAMES + 1);

    localparam logic [2:0]          c_LIVES     = 3'(LIVES);
    localparam logic [2:0]          c_MAX_LEVEL = 3'(MAX_LEVEL);
    localparam logic [c_COOL_W-1:0] c_COOL_LOAD = c_COOL_W'(HIT_COOLDOWN_FRAMES);
    localparam logic [c_COOL_W-1:0] c_COOL_ONE  = c_COOL_W'(1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(SCREEN_HOLD_FRAMES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);

    localparam logic [2:0] c_ST_TITLE       = 3'd0;
    localparam logic [2:0] c_ST_PLAYING     = 3'd1;
    localparam logic [2:0] c_ST_LEVEL_CLEAR = 3'd2;
    localparam logic [2:0] c_ST_GAME_WON    = 3'd3;
    localparam logic [2:0] c_ST_GAME_OVER   = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          r_lives;
    logic [2:0]          r_level;
    logic [c_COOL_W-1:0] r_cool;
    logic [c_HOLD_W-1:0] r_hold;
    logic                r_holdExpired;
    logic                r_levelRestart;
    logic                r_startKeyD;
    logic                w_startPress;

    // Delayed copy of the start key for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_startKeyD <= 1'b0;
        end else begin
            r_startKeyD <= startKey;
        end
    end

    assign w_startPress = startKey & ~r_startKeyD;

    // Game sequencer: screen state, lives, level, cooldown and screen hold.
    // Entering a hold screen always reloads the hold counter and clears the
    // cooldown, which takes precedence over any coincident frame decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= c_ST_TITLE;
            r_lives        <= c_LIVES;
            r_level        <= 3'd1;
            r_cool         <= '0;
            r_hold         <= '0;
            r_holdExpired  <= 1'b0;
            r_levelRestart <= 1'b0;
        end else begin
            r_levelRestart <= 1'b0;
            case (r_state)
                c_ST_TITLE: begin
                    if (w_startPress) begin
                        r_state        <= c_ST_PLAYING;
                        r_lives        <= c_LIVES;
                        r_level        <= 3'd1;
                        r_cool         <= '0;
                        r_levelRestart <= 1'b1;
                    end
                end

                c_ST_PLAYING: begin
                    if (aliensLanded) begin
                        r_state       <= c_ST_GAME_OVER;
                        r_hold        <= c_HOLD_LOAD;
                        r_holdExpired <= 1'b0;
                        r_cool        <= '0;
                    end else if (won) begin
                        r_state       <= (r_level >= c_MAX_LEVEL) ? c_ST_GAME_WON
                                                                  : c_ST_LEVEL_CLEAR;
                        r_hold        <= c_HOLD_LOAD;
                        r_holdExpired <= 1'b0;
                        r_cool        <= '0;
                    end else if (playerHit && (r_cool == '0)) begin
                        if (r_lives <= 3'd1) begin
                            r_lives       <= 3'd0;
                            r_state       <= c_ST_GAME_OVER;
                            r_hold        <= c_HOLD_LOAD;
                            r_holdExpired <= 1'b0;
                            r_cool        <= '0;
                        end else begin
                            r_lives <= r_lives - 3'd1;
                            r_cool  <= c_COOL_LOAD;
                        end
                    end else if (startOfFrame && (r_cool != '0)) begin
                        r_cool <= r_cool - c_COOL_ONE;
                    end
                end

                c_ST_LEVEL_CLEAR: begin
                    if (startOfFrame) begin
                        if (r_hold == '0) begin
                            r_state        <= c_ST_PLAYING;
                            r_levelRestart <= 1'b1;
                            if (r_level < c_MAX_LEVEL) begin
                                r_level <= r_level + 3'd1;
                            end
                        end else begin
                            r_hold <= r_hold - c_HOLD_ONE;
                        end
                    end
                end

                c_ST_GAME_WON, c_ST_GAME_OVER: begin
                    if (r_holdExpired && w_startPress) begin
                        r_state <= c_ST_TITLE;
                    end else if (startOfFrame) begin
                        if (r_hold == '0) begin
                            r_holdExpired <= 1'b1;
                        end else begin
                            r_hold <= r_hold - c_HOLD_ONE;
                        end
                    end
                end

                default: begin
                    r_state <= c_ST_TITLE;
                end
            endcase
        end
    end

    assign levelRestart = r_levelRestart;
    assign titleScreen  = (r_state == c_ST_TITLE);
    assign gameActive   = (r_state == c_ST_PLAYING);
    assign levelClear   = (r_state == c_ST_LEVEL_CLEAR);
    assign gameWon      = (r_state == c_ST_GAME_WON);
    assign gameOver     = (r_state == c_ST_GAME_OVER);
    assign livesLeft    = r_lives;
    assign level        = r_level;
    assign invulnerable = (r_cool != '0);

endmodule
`default_nettype wire

// File: tb/tb_game_state_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_state_controller
// Description : Self-checking bench for game_state_controller: a table of
//               per-cycle vectors followed by hand-written multi-cycle
//               sequences for hold timing, cooldown and reset corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_state_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       startOfFrame = 1'b0;
    logic       startKey = 1'b0;
    logic       won = 1'b0;
    logic       playerHit = 1'b0;
    logic       aliensLanded = 1'b0;
    logic       levelRestart;
    logic       titleScreen;
    logic       gameActive;
    logic       levelClear;
    logic       gameWon;
    logic       gameOver;
    logic [2:0] livesLeft;
    logic [2:0] level;
    logic       invulnerable;

    int nTests = 0;
    int nFail  = 0;

    localparam logic [4:0] c_SC_TITLE = 5'b10000;
    localparam logic [4:0] c_SC_PLAY  = 5'b01000;
    localparam logic [4:0] c_SC_CLEAR = 5'b00100;
    localparam logic [4:0] c_SC_WON   = 5'b00010;
    localparam logic [4:0] c_SC_OVER  = 5'b00001;

    game_state_controller dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .startKey     (startKey),
        .won          (won),
        .playerHit    (playerHit),
        .aliensLanded (aliensLanded),
        .levelRestart (levelRestart),
        .titleScreen  (titleScreen),
        .gameActive   (gameActive),
        .levelClear   (levelClear),
        .gameWon      (gameWon),
        .gameOver     (gameOver),
        .livesLeft    (livesLeft),
        .level        (level),
        .invulnerable (invulnerable)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       sof;
        logic       key;
        logic       wn;
        logic       hit;
        logic       landed;
        logic       expRestart;
        logic [4:0] expScreen;
        logic [2:0] expLives;
        logic [2:0] expLevel;
        logic       expInv;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [4:0] screen();
        return {titleScreen, gameActive, levelClear, gameWon, gameOver};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nTests++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic sof, input logic key, input logic wn,
                        input logic hit, input logic landed);
        startOfFrame = sof;
        startKey     = key;
        won          = wn;
        playerHit    = hit;
        aliensLanded = landed;
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic doReset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_screen", int'(screen()), int'(c_SC_TITLE));
        chk("reset_lives", int'(livesLeft), 3);
        chk("reset_level", int'(level), 1);
        chk("reset_restart", int'(levelRestart), 0);
        chk("reset_inv", int'(invulnerable), 0);
    endtask

    task automatic startGame();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("start_restart", int'(levelRestart), 1);
        chk("start_screen", int'(screen()), int'(c_SC_PLAY));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("start_restart_off", int'(levelRestart), 0);
    endtask

    initial begin
        int restarts;

        //          sof  key  won  hit  land  rst  screen      lives lvl  inv
        vecs[0] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,c_SC_PLAY, 3'd3,3'd1,1'b0};
        vecs[1] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,c_SC_PLAY, 3'd3,3'd1,1'b0};
        vecs[2] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,c_SC_PLAY, 3'd3,3'd1,1'b0};
        vecs[3] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,c_SC_PLAY, 3'd2,3'd1,1'b1};
        vecs[4] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,c_SC_PLAY, 3'd2,3'd1,1'b1};
        vecs[5] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,c_SC_CLEAR,3'd2,3'd1,1'b0};
        vecs[6] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,c_SC_CLEAR,3'd2,3'd1,1'b0};
        vecs[7] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,c_SC_CLEAR,3'd2,3'd1,1'b0};
        vecs[8] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,c_SC_CLEAR,3'd2,3'd1,1'b0};

        // Table-driven vectors from reset.
        doReset();
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].sof, vecs[i].key, vecs[i].wn, vecs[i].hit, vecs[i].landed);
            chk($sformatf("vec%0d_restart", i), int'(levelRestart), int'(vecs[i].expRestart));
            chk($sformatf("vec%0d_screen", i), int'(screen()), int'(vecs[i].expScreen));
            chk($sformatf("vec%0d_lives", i), int'(livesLeft), int'(vecs[i].expLives));
            chk($sformatf("vec%0d_level", i), int'(level), int'(vecs[i].expLevel));
            chk($sformatf("vec%0d_inv", i), int'(invulnerable), int'(vecs[i].expInv));
        end

        // Key held for 10 cycles gives one restart pulse; then cooldown and death.
        doReset();
        restarts = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (levelRestart) restarts++;
        end
        chk("held_key_restarts", restarts, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("held_key_active", int'(gameActive), 1);
        chk("held_key_lives", int'(livesLeft), 3);
        chk("held_key_level", int'(level), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("hit1_lives", int'(livesLeft), 2);
        chk("hit1_inv", int'(invulnerable), 1);
        frames(5);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("hit2_ignored_lives", int'(livesLeft), 2);
        frames(54);
        chk("cool_frame59_inv", int'(invulnerable), 1);
        frames(1);
        chk("cool_frame60_inv", int'(invulnerable), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("hit3_lives", int'(livesLeft), 1);
        chk("hit3_inv", int'(invulnerable), 1);
        frames(60);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lethal_screen", int'(screen()), int'(c_SC_OVER));
        chk("lethal_lives", int'(livesLeft), 0);
        chk("lethal_inv", int'(invulnerable), 0);
        frames(50);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("over_key_f50", int'(screen()), int'(c_SC_OVER));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frames(69);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("over_key_f119", int'(screen()), int'(c_SC_OVER));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frames(1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("over_key_expired", int'(screen()), int'(c_SC_TITLE));
        chk("over_to_title_restart", int'(levelRestart), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Level progression to game won.
        doReset();
        startGame();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("won_l1_screen", int'(screen()), int'(c_SC_CLEAR));
        frames(119);
        chk("clear_f119_screen", int'(screen()), int'(c_SC_CLEAR));
        chk("clear_f119_restart", int'(levelRestart), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clear_f120_screen", int'(screen()), int'(c_SC_PLAY));
        chk("clear_f120_level", int'(level), 2);
        chk("clear_f120_restart", int'(levelRestart), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clear_restart_off", int'(levelRestart), 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        frames(120);
        chk("l3_screen", int'(screen()), int'(c_SC_PLAY));
        chk("l3_level", int'(level), 3);
        chk("l3_lives", int'(livesLeft), 3);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("gamewon_screen", int'(screen()), int'(c_SC_WON));
        frames(119);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("gamewon_key_f119", int'(screen()), int'(c_SC_WON));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frames(1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("gamewon_to_title", int'(screen()), int'(c_SC_TITLE));
        chk("gamewon_title_restart", int'(levelRestart), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        startGame();
        chk("restart_level", int'(level), 1);
        chk("restart_lives", int'(livesLeft), 3);

        // All three events together: aliens landing wins.
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("triple_screen", int'(screen()), int'(c_SC_OVER));
        chk("triple_lives", int'(livesLeft), 3);

        // Asynchronous reset in the middle of a level-clear hold.
        doReset();
        startGame();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        frames(79);
        chk("mid_clear_screen", int'(screen()), int'(c_SC_CLEAR));
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_screen", int'(screen()), int'(c_SC_TITLE));
        chk("async_rst_lives", int'(livesLeft), 3);
        chk("async_rst_level", int'(level), 1);
        chk("async_rst_restart", int'(levelRestart), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        startGame();
        chk("post_rst_level", int'(level), 1);
        chk("post_rst_lives", int'(livesLeft), 3);
        chk("post_rst_active", int'(gameActive), 1);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_state_controller.md
Name: game_state_controller

Overview:
- Top-level game sequencer downstream of the win detector.
- Consumes the sticky won flag, player-hit pulses and alien-landed pulses, and decides the game screen: title, playing, level clear, game won or game over.
- Tracks lives, current level and a post-hit invulnerability window.
- Emits a one-cycle levelRestart pulse that re-arms the win detector and the alien matrix for each new level.

Parameters:
- LIVES, 3, starting lives; legal range 1..7.
- MAX_LEVEL, 3, number of levels to clear for a game win; legal range 1..7.
- SCREEN_HOLD_FRAMES, 120, frames a clear/won/over screen is held before it responds.
- HIT_COOLDOWN_FRAMES, 60, invulnerability frames after a non-lethal hit.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- startKey  in  1  start button level; the block edge-detects it internally.
- won  in  1  sticky "all aliens dead" flag from the win detector.
- playerHit  in  1  one-cycle player/bullet collision pulse.
- aliensLanded  in  1  one-cycle pulse when an alien reaches the player row.
- levelRestart  out  1  registered one-cycle pulse; re-arms level logic.
- titleScreen  out  1  state==TITLE.
- gameActive  out  1  state==PLAYING.
- levelClear  out  1  state==LEVEL_CLEAR.
- gameWon  out  1  state==GAME_WON.
- gameOver  out  1  state==GAME_OVER.
- livesLeft  out  3  remaining lives.
- level  out  3  current level, 1-based.
- invulnerable  out  1  hit cooldown active.

Behaviour:
- Reset (async, active-high), held for its full duration:
  - state=TITLE, livesLeft=LIVES, level=1.
  - cooldown=0, holdCnt=0, levelRestart=0.
  - Internal startKey delay register=0, so a key held through reset does not produce an edge.
- Start pulse: startPress = startKey & ~startKey_d, computed from a 1-cycle delayed copy.
- Screen outputs are a one-hot decode of the state register. No combinational path from any input to any output.
- TITLE:
  - On startPress: go to PLAYING, livesLeft=LIVES, level=1, cooldown=0.
  - levelRestart=1 in the cycle after the edge.
- PLAYING: events are evaluated in this priority order in a single cycle.
  1. aliensLanded: go to GAME_OVER; livesLeft unchanged.
  2. won: if level==MAX_LEVEL go to GAME_WON, otherwise go to LEVEL_CLEAR.
  3. playerHit with cooldown==0:
     - If livesLeft==1: livesLeft=0, go to GAME_OVER.
     - Otherwise: livesLeft-1, cooldown=HIT_COOLDOWN_FRAMES.
  4. playerHit with cooldown!=0: ignored.
  - Lower-priority events in the same cycle as a higher one are dropped, not queued.
  - cooldown decrements on each startOfFrame while non-zero; it never wraps below 0.
  - invulnerable = (cooldown!=0).
- Screen hold timing:
  - Entering LEVEL_CLEAR, GAME_WON or GAME_OVER loads holdCnt=SCREEN_HOLD_FRAMES-1 and clears cooldown.
  - On each startOfFrame in these states: if holdCnt==0 the hold is expired and holdCnt stays 0; otherwise holdCnt decrements.
  - The hold therefore spans exactly SCREEN_HOLD_FRAMES startOfFrame pulses.
- LEVEL_CLEAR: on the startOfFrame where holdCnt is already 0:
  - level+1, go to PLAYING, levelRestart=1 next cycle.
  - livesLeft is preserved.
- GAME_WON / GAME_OVER:
  - startPress is ignored until the hold has expired.
  - After expiry, startPress goes to TITLE. levelRestart is not pulsed; it pulses later on TITLE→PLAYING.
- won is sticky upstream and is only acted on in PLAYING. In PLAYING it is treated as level-sensitive: the levelRestart pulse clears it upstream before the next PLAYING cycle that could matter. It is ignored in every other state.
- startOfFrame coincident with a state-changing event: the event transition takes effect and the counter load overrides the decrement.
- Arithmetic: livesLeft, level, cooldown and holdCnt saturate and never wrap. level never exceeds MAX_LEVEL.

Test Plan:
- Reset, then startKey held high for 10 cycles → exactly one levelRestart pulse; gameActive=1, livesLeft=3, level=1.
- In PLAYING, playerHit at t0, then playerHit 5 frames later → livesLeft=2 and invulnerable=1 for 60 frames; second hit ignored; third hit after 61 frames gives livesLeft=1.
- livesLeft=1, playerHit → gameOver=1, livesLeft=0. startKey edge at frame 50 ignored; edge at frame 121 → titleScreen=1.
- won at level 1 (MAX_LEVEL=3) → levelClear=1 for 120 frames, then level=2, levelRestart pulse, gameActive=1. At level 3, won → gameWon=1.
- won, aliensLanded and playerHit in the same cycle → GAME_OVER, livesLeft unchanged. won and playerHit in the same cycle → LEVEL_CLEAR, livesLeft unchanged.
- reset asserted mid-LEVEL_CLEAR with holdCnt=40 → all outputs return to reset values immediately; after release, startKey edge → level=1, livesLeft=3.
